// File: rtl/algo_1r2w_b90_wr_sched.sv
// Write-port scheduler for the 1R2W memory: round-robin grants up to two writers per cycle,
// keeps same-address writes out of the same cycle and registers the memory write ports.
module algo_1r2w_b90_wr_sched #(
    parameter int WIDTH   = 32,
    parameter int BITADDR = 13,
    parameter int NUMREQ  = 4,
    parameter int BITREQ  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_ready,
    input  logic [NUMREQ-1:0]         req_vld,
    input  logic [NUMREQ*BITADDR-1:0] req_adr,
    input  logic [NUMREQ*WIDTH-1:0]   req_din,
    output logic [NUMREQ-1:0]         req_rdy,
    output logic [1:0]                write,
    output logic [2*BITADDR-1:0]      wr_adr,
    output logic [2*WIDTH-1:0]        din,
    output logic [15:0]               coll_cnt
);

    logic [BITADDR-1:0] reqAdrArr [NUMREQ];
    logic [WIDTH-1:0]   reqDinArr [NUMREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUMREQ; gi++) begin : gUnpack
            assign reqAdrArr[gi] = req_adr[gi*BITADDR +: BITADDR];
            assign reqDinArr[gi] = req_din[gi*WIDTH +: WIDTH];
        end
    endgenerate

    logic [BITREQ-1:0]  rrPtr;
    logic               found0;
    logic               found1;
    logic               deferHit;
    logic [BITREQ-1:0]  slot0Idx;
    logic [BITREQ-1:0]  slot1Idx;
    logic [BITADDR-1:0] slot0Adr;
    logic [BITREQ-1:0]  lastIdx;
    logic [BITREQ-1:0]  ptrNext;

    // Scan from rrPtr with wrap; the deferral flag is only raised while port 1 is still free,
    // since after that a requester is skipped for lack of a port, not for its address.
    always_comb begin
        int                scanIdx;
        logic [BITREQ-1:0] idx;
        found0   = 1'b0;
        found1   = 1'b0;
        deferHit = 1'b0;
        slot0Idx = '0;
        slot1Idx = '0;
        slot0Adr = '0;
        scanIdx  = 0;
        idx      = '0;
        for (int k = 0; k < NUMREQ; k++) begin
            scanIdx = int'(rrPtr) + k;
            if (scanIdx >= NUMREQ) begin
                scanIdx = scanIdx - NUMREQ;
            end
            idx = BITREQ'(scanIdx);
            if (mem_ready && req_vld[idx]) begin
                if (!found0) begin
                    found0   = 1'b1;
                    slot0Idx = idx;
                    slot0Adr = reqAdrArr[idx];
                end else if (!found1) begin
                    if (reqAdrArr[idx] != slot0Adr) begin
                        found1   = 1'b1;
                        slot1Idx = idx;
                    end else begin
                        deferHit = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        req_rdy = '0;
        if (!rst) begin
            if (found0) begin
                req_rdy[slot0Idx] = 1'b1;
            end
            if (found1) begin
                req_rdy[slot1Idx] = 1'b1;
            end
        end
    end

    always_comb begin
        lastIdx = found1 ? slot1Idx : slot0Idx;
        ptrNext = (lastIdx == BITREQ'(NUMREQ - 1)) ? '0 : lastIdx + 1'b1;
    end

    // Ungranted port address/data registers keep their old contents; write alone qualifies them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrPtr    <= '0;
            write    <= '0;
            wr_adr   <= '0;
            din      <= '0;
            coll_cnt <= '0;
        end else begin
            write <= {found1, found0};
            if (found0) begin
                wr_adr[0 +: BITADDR] <= reqAdrArr[slot0Idx];
                din[0 +: WIDTH]      <= reqDinArr[slot0Idx];
                rrPtr                <= ptrNext;
            end
            if (found1) begin
                wr_adr[BITADDR +: BITADDR] <= reqAdrArr[slot1Idx];
                din[WIDTH +: WIDTH]        <= reqDinArr[slot1Idx];
            end
            if (deferHit && coll_cnt != 16'hFFFF) begin
                coll_cnt <= coll_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/algo_1r2w_b90_wr_sched.md
# algo_1r2w_b90_wr_sched

Write-port scheduler in front of the 1-read/2-write algorithmic memory top wrap. It accepts write requests from NUMREQ independent requesters over valid/ready handshakes and grants up to two per cycle with round-robin fairness. It resolves same-address conflicts between the two grants and drives the memory's registered `write`/`wr_adr`/`din` ports. While the memory `ready` output is low (init/refresh), all grants are held off.

## Interface
- WIDTH, 32, data word width
- BITADDR, 13, address width
- NUMREQ, 4, number of write requesters (2..8)
- BITREQ, 2, clog2(NUMREQ)
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- mem_ready  input  1  ready from memory; low = no writes may issue
- req_vld  input  NUMREQ  per-requester write request
- req_adr  input  NUMREQ*BITADDR  request addresses, requester i at [i*BITADDR +: BITADDR]
- req_din  input  NUMREQ*WIDTH  request data, requester i at [i*WIDTH +: WIDTH]
- req_rdy  output  NUMREQ  combinational accept; transfer when req_vld[i]&req_rdy[i]
- write  output  2  registered write enables to memory ports 0/1
- wr_adr  output  2*BITADDR  registered addresses, port 0 in low BITADDR bits
- din  output  2*WIDTH  registered data, port 0 in low WIDTH bits
- coll_cnt  output  16  saturating count of cycles with a same-address deferral

## Operation
- State: rr_ptr (BITREQ bits), output registers write/wr_adr/din, coll_cnt.
- Per cycle with mem_ready=1 and rst=0: scan requesters in order rr_ptr, rr_ptr+1, …, wrapping modulo NUMREQ.
  - First requester with req_vld=1 is slot 0 and drives port 0.
  - Next requester in scan order with req_vld=1 and req_adr != slot-0 address is slot 1 and drives port 1.
  - Valid requesters that are skipped only because their address equals slot 0's are deferred. Any deferral in a cycle increments coll_cnt by 1, saturating at 0xFFFF.
- req_rdy[i]=1 only for the granted slot-0/slot-1 requesters; at most two bits set.
- rr_ptr update:
  - Next value = (index of last granted requester + 1) mod NUMREQ.
  - Last granted = slot 1 if present, else slot 0.
  - Unchanged if no grant.
- Port data registers:
  - wr_adr/din for a granted slot take the requester's address/data.
  - For an ungranted slot, they hold their previous value; only write gates them.
- mem_ready=0: req_rdy=0, no grants, rr_ptr and coll_cnt hold, write registered to 0.
- Requester ordering: one requester's successive accepted writes issue in acceptance order. Two requesters to the same address never issue in the same cycle.

## Timing
- Reset (async assert): write=0, wr_adr=0, din=0, rr_ptr=0, coll_cnt=0. req_rdy is forced 0 while rst=1.
- Latency: request accepted in cycle N → write/wr_adr/din valid in cycle N+1, for exactly one cycle.
- req_rdy is combinational from req_vld, req_adr, rr_ptr, mem_ready. Requesters must not make req_vld depend on req_rdy.
- mem_ready falling in cycle N: no acceptance in N. Writes accepted in N-1 still issue in N; the memory tolerates this one-cycle overlap.
- Reset asserted mid-operation: outputs clear immediately; requests in flight are dropped. Requesters re-present after rst deasserts.
- Back-to-back: full throughput of 2 writes/cycle when ≥2 distinct-address requests are valid.
- Wrap: rr_ptr = NUMREQ-1 with last grant at NUMREQ-1 → rr_ptr = 0.

## Test plan
- Reset: hold rst=1 with all req_vld=1 → req_rdy=0000, write=00 and coll_cnt=0 throughout; after release, first cycle grants requesters 0 and 1.
- Fairness: NUMREQ=4, all valid continuously with distinct addresses. Grants must be {0,1},{2,3},{0,1},…, and write=11 every cycle from cycle 1.
- Collision: req0 adr=0x010, req1 adr=0x010, req2 adr=0x020, rr_ptr=0. Cycle N: rdy=0101, port0=0x010, port1=0x020, coll_cnt 0→1. Cycle N+1: req1 granted on port0, write=01.
- mem_ready gating: mem_ready=0 for 5 cycles with req3 valid → rdy=0, write=00, rr_ptr holds. mem_ready=1 → req3 granted, write asserts next cycle with req3's data.
- Single requester, wrap: only req3 valid, rr_ptr=2 → req3 on port0, rr_ptr→0, write=01, wr_adr[12:0]=req3 adr.
- Saturation: force 70000 collision cycles → coll_cnt stops at 0xFFFF and does not wrap.
